// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port RAM between the
// instruction and data cache miss ports (IDLE/ISSUE/WAIT/RESP sequencer).
module mem_port_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int MEM_LAT   = 2,
  parameter int DATA_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          grant
);

  localparam int CW =
    (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_grant;
  logic            r_last;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_irdata;
  logic [DW-1:0]   r_drdata;

  logic            w_any;
  logic            w_win_d;
  logic            w_take;
  logic            w_done;
  logic            w_cap;

  assign w_any = i_req | d_req;

  // Tie goes to data under priority mode, else
  // to whichever port did not win last time.
  always_comb begin
    w_win_d = 1'b0;
    unique case (1'b1)
      (i_req && d_req):
        w_win_d = (DATA_PRIO != 0) || !r_last;
      (d_req && !i_req):
        w_win_d = 1'b1;
      default:
        w_win_d = 1'b0;
    endcase
  end

  assign w_take = (r_state == IDLE) && w_any;
  assign w_done = (r_state == WAIT) &&
                  (r_cnt == '0);
  assign w_cap  = w_done && !r_we;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_done) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latch; r_last starts at 1 so the
  // instruction port wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_take) begin
      r_grant <= w_win_d;
      r_last  <= w_win_d;
      if (w_win_d) begin
        r_we    <= d_we;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
      end else begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end
  end

  // Counter hits zero in the cycle ram_rdata
  // is valid, MEM_LAT cycles after the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_cnt <= CW'(MEM_LAT - 1);
    end else if ((r_state == WAIT) &&
                 (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irdata <= '0;
      r_drdata <= '0;
    end else if (w_cap) begin
      if (r_grant) begin
        r_drdata <= ram_rdata;
      end else begin
        r_irdata <= ram_rdata;
      end
    end
  end

  assign ram_en    = (r_state == ISSUE);
  assign ram_we    = ram_en & r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;

  assign i_ack   = (r_state == RESP) & ~r_grant;
  assign d_ack   = (r_state == RESP) & r_grant;
  assign i_rdata = r_irdata;
  assign d_rdata = r_drdata;
  assign busy    = (r_state != IDLE);
  assign grant   = r_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: four arbiter builds (rr, data-prio, lat1, lat4)
// with RAM models and an in-order completion scoreboard.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  i_req, i_we, d_req, d_we, pl_en;
  logic [7:0]  i_addr_a [4];
  logic [7:0]  d_addr_a [4];
  logic [31:0] i_wdata_a [4];
  logic [31:0] d_wdata_a [4];
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  wire [3:0]  i_ack, d_ack, ram_en, ram_we;
  wire [3:0]  busy, grant;
  wire [31:0] i_rdata_a [4];
  wire [31:0] d_rdata_a [4];
  wire [7:0]  ram_addr_a [4];
  wire [31:0] ram_wdata_a [4];
  wire [31:0] ram_rdata_a [4];

  for (genvar g = 0; g < 4; g++) begin : g_env
    localparam int L =
      (g == 2) ? 1 : (g == 3) ? 4 : 2;
    localparam int P = (g == 1) ? 1 : 0;

    mem_port_arbiter #(
      .DW(32), .AW(8),
      .MEM_LAT(L), .DATA_PRIO(P)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req[g]),
      .i_we      (i_we[g]),
      .i_addr    (i_addr_a[g]),
      .i_wdata   (i_wdata_a[g]),
      .i_ack     (i_ack[g]),
      .i_rdata   (i_rdata_a[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr_a[g]),
      .d_wdata   (d_wdata_a[g]),
      .d_ack     (d_ack[g]),
      .d_rdata   (d_rdata_a[g]),
      .ram_en    (ram_en[g]),
      .ram_we    (ram_we[g]),
      .ram_addr  (ram_addr_a[g]),
      .ram_wdata (ram_wdata_a[g]),
      .ram_rdata (ram_rdata_a[g]),
      .busy      (busy[g]),
      .grant     (grant[g])
    );

    logic [31:0] mem [256];
    logic [31:0] pipe [L];

    always_ff @(posedge clk) begin
      if (pl_en[g])
        mem[pl_addr] <= pl_data;
      else if (ram_en[g] && ram_we[g])
        mem[ram_addr_a[g]] <= ram_wdata_a[g];
      pipe[0] <= ram_en[g] ?
        mem[ram_addr_a[g]] : 32'h0;
      for (int k = 1; k < L; k++)
        pipe[k] <= pipe[k-1];
    end
    assign ram_rdata_a[g] = pipe[L-1];
  end

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] exp_i [4];
  logic [31:0] exp_d [4];

  int n_vec = 0;
  int n_err = 0;
  int en_cnt, we_cnt, en_first;
  logic [7:0]  en_addr;
  logic [31:0] we_data;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic push(input int port,
                      input logic [31:0] data,
                      input int c);
    exp_t e;
    e.port = port;
    e.data = data;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic sync(output int n);
    @(posedge clk);
    #1;
    n = cyc;
  endtask

  task automatic preload(input int g,
                         input logic [7:0] a,
                         input logic [31:0] d);
    @(negedge clk);
    pl_en[g] = 1'b1;
    pl_addr  = a;
    pl_data  = d;
    @(negedge clk);
    pl_en[g] = 1'b0;
  endtask

  task automatic set_i(input int g,
                       input logic we,
                       input logic [7:0] a,
                       input logic [31:0] d);
    i_req[g]     = 1'b1;
    i_we[g]      = we;
    i_addr_a[g]  = a;
    i_wdata_a[g] = d;
  endtask

  task automatic set_d(input int g,
                       input logic we,
                       input logic [7:0] a,
                       input logic [31:0] d);
    d_req[g]     = 1'b1;
    d_we[g]      = we;
    d_addr_a[g]  = a;
    d_wdata_a[g] = d;
  endtask

  // Plays both requesters: each drops req
  // on its last expected ack.
  task automatic run(input int g,
                     input int ni,
                     input int nd,
                     input int budget);
    int   ri, rd, t;
    exp_t e;
    ri = ni;
    rd = nd;
    t  = 0;
    en_cnt   = 0;
    we_cnt   = 0;
    en_first = -1;
    while ((ri + rd) > 0 && t < budget) begin
      @(negedge clk);
      t++;
      if (ram_en[g]) begin
        en_cnt++;
        en_addr = ram_addr_a[g];
        if (en_first < 0) en_first = cyc;
      end
      if (ram_we[g]) begin
        we_cnt++;
        we_data = ram_wdata_a[g];
      end
      if (i_ack[g] || d_ack[g]) begin
        chk("sb_empty", sb.size() == 0, 0);
        chk("dual_ack",
            i_ack[g] && d_ack[g], 0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("ack_port", d_ack[g], e.port);
          chk("ack_cyc", cyc, e.cyc);
          chk("grant", grant[g], e.port);
          if (e.port == 0) exp_i[g] = e.data;
          else             exp_d[g] = e.data;
          chk("i_rdata", i_rdata_a[g], exp_i[g]);
          chk("d_rdata", d_rdata_a[g], exp_d[g]);
        end
        if (i_ack[g] && ri > 0) begin
          ri--;
          if (ri == 0) i_req[g] = 1'b0;
        end
        if (d_ack[g] && rd > 0) begin
          rd--;
          if (rd == 0) d_req[g] = 1'b0;
        end
      end
    end
    chk("acks_left", ri + rd, 0);
    i_req[g] = 1'b0;
    d_req[g] = 1'b0;
    sb.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst     = 1'b0;
    i_req   = '0;
    i_we    = '0;
    d_req   = '0;
    d_we    = '0;
    pl_en   = '0;
    pl_addr = '0;
    pl_data = '0;
    for (int g = 0; g < 4; g++) begin
      i_addr_a[g]  = '0;
      d_addr_a[g]  = '0;
      i_wdata_a[g] = '0;
      d_wdata_a[g] = '0;
      exp_i[g]     = '0;
      exp_d[g]     = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("rst_busy", busy[g], 0);
      chk("rst_en", ram_en[g], 0);
      chk("rst_we", ram_we[g], 0);
      chk("rst_addr", ram_addr_a[g], 0);
      chk("rst_wdata", ram_wdata_a[g], 0);
      chk("rst_grant", grant[g], 0);
      chk("rst_ack", {i_ack[g], d_ack[g]}, 0);
      chk("rst_irdata", i_rdata_a[g], 0);
      chk("rst_drdata", d_rdata_a[g], 0);
    end
    @(negedge clk);
    rst = 1'b1;

    preload(0, 8'h10, 32'hDEADBEEF);
    sync(n);
    set_i(0, 1'b0, 8'h10, 32'h0);
    push(0, 32'hDEADBEEF, n + 4);
    run(0, 1, 0, 30);
    chk("rd_en_cyc", en_first, n + 1);
    chk("rd_en_cnt", en_cnt, 1);
    chk("rd_we_cnt", we_cnt, 0);
    chk("rd_addr", en_addr, 8'h10);

    sync(n);
    set_d(0, 1'b1, 8'h3F, 32'h12345678);
    push(1, exp_d[0], n + 4);
    run(0, 0, 1, 30);
    chk("wr_en_cyc", en_first, n + 1);
    chk("wr_we_cnt", we_cnt, 1);
    chk("wr_data", we_data, 32'h12345678);
    chk("wr_addr", en_addr, 8'h3F);
    sync(n);
    set_d(0, 1'b0, 8'h3F, 32'h0);
    push(1, 32'h12345678, n + 4);
    run(0, 0, 1, 30);
    chk("rb_we_cnt", we_cnt, 0);
    chk("rb_en_cnt", en_cnt, 1);

    preload(0, 8'h20, 32'hAAAA0001);
    preload(0, 8'h21, 32'hBBBB0002);
    sync(n);
    set_i(0, 1'b0, 8'h20, 32'h0);
    set_d(0, 1'b0, 8'h21, 32'h0);
    push(0, 32'hAAAA0001, n + 4);
    push(1, 32'hBBBB0002, n + 9);
    push(0, 32'hAAAA0001, n + 14);
    push(1, 32'hBBBB0002, n + 19);
    push(0, 32'hAAAA0001, n + 24);
    run(0, 3, 2, 60);
    chk("rr_en_cnt", en_cnt, 5);

    preload(1, 8'h30, 32'hC0DE0001);
    preload(1, 8'h31, 32'hC0DE0002);
    preload(1, 8'h32, 32'hC0DE0003);
    preload(1, 8'h33, 32'hC0DE0004);
    sync(n);
    set_i(1, 1'b0, 8'h30, 32'h0);
    push(0, 32'hC0DE0001, n + 4);
    run(1, 1, 0, 30);
    sync(n);
    set_d(1, 1'b0, 8'h31, 32'h0);
    push(1, 32'hC0DE0002, n + 4);
    run(1, 0, 1, 30);
    sync(n);
    set_i(1, 1'b0, 8'h32, 32'h0);
    set_d(1, 1'b0, 8'h33, 32'h0);
    push(1, 32'hC0DE0004, n + 4);
    push(0, 32'hC0DE0003, n + 9);
    run(1, 1, 1, 40);

    preload(2, 8'h40, 32'hA5A5A5A5);
    sync(n);
    set_i(2, 1'b0, 8'h40, 32'h0);
    push(0, 32'hA5A5A5A5, n + 3);
    run(2, 1, 0, 30);
    chk("l1_en_cyc", en_first, n + 1);

    preload(3, 8'h40, 32'hA5A5A5A5);
    sync(n);
    set_i(3, 1'b0, 8'h40, 32'h0);
    push(0, 32'hA5A5A5A5, n + 6);
    run(3, 1, 0, 30);
    chk("l4_en_cyc", en_first, n + 1);

    sync(n);
    set_i(0, 1'b0, 8'h10, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", busy[0], 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_en", ram_en[0], 0);
    chk("mid_rst_ack",
        {i_ack[0], d_ack[0]}, 0);
    chk("mid_rst_irdata", i_rdata_a[0], 0);
    i_req[0] = 1'b0;
    for (int g = 0; g < 4; g++) begin
      exp_i[g] = '0;
      exp_d[g] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sync(n);
    set_i(0, 1'b0, 8'h10, 32'h0);
    set_d(0, 1'b0, 8'h3F, 32'h0);
    push(0, 32'hDEADBEEF, n + 4);
    push(1, 32'h12345678, n + 9);
    run(0, 1, 1, 40);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
